avalon_pio_out_handshake: RTL
=============================

Name: avalon_pio_out_handshake

Overview:
Avalon-MM slave that drives fabric-side outputs from the HPS/Nios bus. It is the write-side counterpart of the read-only input PIO.
- Holds a read/write output data register with atomic set and clear aliases.
- Launches commands to fabric logic over a four-phase req/ack handshake, with status and overrun reporting.
- Sits on the lightweight bridge next to the input PIOs in Computer_System.

Parameters:
DATA_WIDTH, 8, width of out_port, cmd_data and the data registers (1..32)
RESET_VALUE, 0, value loaded into the DATA register on reset

Ports:
clk  input  1  system clock
reset_n  input  1  reset, synchronous, active-low
address  input  3  Avalon register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data; bits above DATA_WIDTH ignored
readdata  output  32  registered read data, zero-extended
out_port  output  DATA_WIDTH  DATA register contents
cmd_data  output  DATA_WIDTH  last accepted command word
cmd_req  output  1  command request to fabric
cmd_ack  input  1  fabric acknowledge, synchronous to clk

Behaviour:
- Reset is synchronous, active-low, sampled on the clk rising edge. Reset values:
  - DATA = RESET_VALUE, so out_port = RESET_VALUE.
  - cmd_data = 0, cmd_req = 0, overrun = 0.
  - FSM = IDLE, readdata = 0.
- Write is valid when chipselect=1 and write_n=0. All writes take effect at the next clk edge, so a new value is visible on its output one cycle after the write.
- Register map:
  - 0 DATA, R/W: a write loads writedata[DATA_WIDTH-1:0].
  - 1 STATUS, R: bit0 busy (FSM != IDLE), bit1 overrun (sticky), bit2 cmd_ack live value. Writing 1 to bit1 clears overrun; other bits are ignored.
  - 2 COMMAND, R/W: read returns cmd_data. A write while in IDLE loads cmd_data and starts the handshake. A write while not in IDLE is dropped, leaves cmd_data unchanged and sets overrun.
  - 4 OUTSET, W: DATA <= DATA | writedata.
  - 5 OUTCLEAR, W: DATA <= DATA & ~writedata.
  - 3, 6, 7 reserved: reads return 0, writes have no effect. Reads of OUTSET and OUTCLEAR return 0.
- Read path:
  - readdata is updated every clock with the mux output for the current address.
  - Fixed read latency of 1 cycle, no wait states.
  - The read is not qualified by chipselect and has no side effects.
  - Reads return register values as they were before the write edge (old value on a same-cycle read).
- Handshake FSM, states IDLE, REQ, RELEASE:
  - IDLE: on an accepted COMMAND write, go to REQ and set cmd_req=1 at the same edge that loads cmd_data.
  - REQ: hold cmd_req=1 and cmd_data stable until cmd_ack=1 is sampled. Then set cmd_req=0 and go to RELEASE.
  - RELEASE: wait until cmd_ack=0 is sampled, then go to IDLE.
  - cmd_ack already high at launch does not short-circuit; the FSM waits in REQ for ack sampled high after req rises.
  - cmd_ack pulses while in IDLE are ignored.
  - No timeout: the FSM waits indefinitely in REQ or RELEASE.
- Overrun:
  - If a set event and a write-1-clear of overrun occur in the same cycle, set wins.
  - Overrun has no effect on FSM progress.
- Reset mid-handshake: cmd_req drops at the reset edge and the FSM returns to IDLE regardless of cmd_ack. Fabric must tolerate an abandoned request.
- Width rules:
  - writedata bits [31:DATA_WIDTH] are discarded.
  - readdata bits above DATA_WIDTH and above bit2 of STATUS read 0.

Test Plan:
- Reset with RESET_VALUE=8'h5A: hold reset_n=0 for 2 edges -> out_port=8'h5A, cmd_req=0, readdata=0; read addr1 -> 32'h0 (cmd_ack low).
- Write DATA=8'hF0, OUTSET=8'h0F, OUTCLEAR=8'h81 on consecutive cycles -> out_port goes F0, FF, 7E; each value visible 1 cycle after its write; read addr0 -> 32'h7E.
- Write COMMAND=8'h3C with cmd_ack=0 -> next cycle cmd_req=1, cmd_data=3C, STATUS=1. Raise ack 5 cycles later -> req falls the cycle after ack is sampled, STATUS stays 1. Drop ack -> STATUS=0 one cycle after ack is sampled low.
- While busy, write COMMAND=8'h99 -> cmd_data stays 3C, STATUS bit1=1. Write STATUS=2 -> bit1 clears. Issue a same-cycle clear and a new overrun -> bit1 remains 1.
- cmd_ack held high before the COMMAND write -> FSM goes to REQ, immediately samples ack=1 and drops req. Verify req is high for exactly 1 cycle and FSM stays in RELEASE until ack falls.
- Assert reset_n=0 while in REQ -> at that edge cmd_req=0, STATUS=0, out_port=RESET_VALUE. Write to addr 6 -> no state change; read addr 6 -> 0.

Source files
------------

// File: rtl/avalon_pio_out_handshake.sv
// Avalon-MM output PIO: DATA register with set/clear aliases plus a four-phase
// req/ack command launcher toward fabric logic, with busy/overrun status.
module avalon_pio_out_handshake #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_req,
    input  logic                  cmd_ack
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_STATUS   = 3'd1,
        ADDR_COMMAND  = 3'd2,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5
    } addr_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                  overrun_q, overrun_d;
    logic [31:0]           read_mux;

    logic [DATA_WIDTH-1:0] wr_word;
    logic                  wr_en;
    logic                  busy;
    logic                  cmd_write;

    assign wr_word   = writedata[DATA_WIDTH-1:0];
    assign wr_en     = chipselect && !write_n;
    assign busy      = (state_q != IDLE);
    assign cmd_write = wr_en && (address == ADDR_COMMAND);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cmd_data_d = cmd_data_q;
        overrun_d  = overrun_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wr_word;
                ADDR_OUTSET:   data_d = data_q | wr_word;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_word;
                default:       ;
            endcase
        end

        // The set term is evaluated last so it wins over a concurrent clear.
        if (wr_en && (address == ADDR_STATUS) && writedata[1])
            overrun_d = 1'b0;
        if (cmd_write && busy)
            overrun_d = 1'b1;

        // Ack is only looked at from REQ onward, so an ack already high at launch
        // still costs one REQ cycle before release.
        case (state_q)
            IDLE: begin
                if (cmd_write) begin
                    cmd_data_d = wr_word;
                    state_d    = REQ;
                end
            end
            REQ:     if (cmd_ack)  state_d = RELEASE;
            RELEASE: if (!cmd_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux = 32'(data_q);
            ADDR_STATUS:  read_mux = {29'd0, cmd_ack, overrun_q, busy};
            ADDR_COMMAND: read_mux = 32'(cmd_data_q);
            default:      read_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= RESET_VALUE;
            cmd_data_q <= '0;
            overrun_q  <= 1'b0;
            readdata   <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cmd_data_q <= cmd_data_d;
            overrun_q  <= overrun_d;
            readdata   <= read_mux;
        end
    end

    assign out_port = data_q;
    assign cmd_data = cmd_data_q;
    assign cmd_req  = (state_q == REQ);

endmodule
